// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// rv_pkg: shared widths and types for the ready/valid enqueue source.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  typedef logic [DROP_CNT_W-1:0] rv_count_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy has to represent DEPTH itself, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ready_valid_enq_source_if.sv
//------------------------------------------------------------------------------
// ready_valid_enq_source_if: dequeue-side ready/valid channel bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ready_valid_enq_source_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] O_data;
  logic             O_valid;
  logic             O_ready;

  modport master (output O_data, output O_valid, input O_ready);
  modport slave  (input O_data, input O_valid, output O_ready);
endinterface

`default_nettype wire

// File: rtl/rv_fifo_mem.sv
//------------------------------------------------------------------------------
// rv_fifo_mem: DEPTH x WIDTH register array, one write port, registered read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv_fifo_mem
  import rv_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    we,
  input  wire logic [ptr_w(DEPTH)-1:0] waddr,
  input  wire logic [WIDTH-1:0]        wdata,
  input  wire logic                    load,
  input  wire logic                    bypass,
  input  wire logic [ptr_w(DEPTH)-1:0] raddr,
  output logic      [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Bypass covers the word landing in a slot that becomes the head this same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (load) begin
      rdata <= bypass ? wdata : r_mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ready_valid_enq_source.sv
//------------------------------------------------------------------------------
// ready_valid_enq_source: strobe-driven producer feeding a registered FIFO that
// drives a back-pressured ready/valid channel. Optional macro RV_DROP_CNT_EN
// adds a saturating drop_cnt output counting refused pushes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ready_valid_enq_source
  import rv_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  wire logic             CLK,
  input  wire logic             RESETN,
  input  wire logic             I0,
  input  wire logic [WIDTH-1:0] I1,
  output logic                  full,
`ifdef RV_DROP_CNT_EN
  output rv_count_t             drop_cnt,
`endif
  ready_valid_enq_source_if.master deq
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_valid;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_rd_next;
  logic             w_bypass;

  always_comb begin
    w_push       = I0 & ~r_full;
    w_pop        = r_valid & deq.O_ready;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    // FIFO empty once the pop is taken: the incoming word becomes the head.
    w_bypass     = w_push & (r_count == CNT_W'(w_pop));
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_DEPTH);
      r_valid <= (w_count_next != '0);
    end
  end

  rv_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (CLK),
    .rst_n  (RESETN),
    .we     (w_push),
    .waddr  (r_wr_ptr),
    .wdata  (I1),
    .load   (w_count_next != '0),
    .bypass (w_bypass),
    .raddr  (w_rd_next),
    .rdata  (deq.O_data)
  );

`ifdef RV_DROP_CNT_EN
  rv_count_t r_drop_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_drop_cnt <= '0;
    end else if (I0 && r_full && (r_drop_cnt != DROP_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + rv_count_t'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign full        = r_full;
  assign deq.O_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_ready_valid_enq_source.sv
//------------------------------------------------------------------------------
// tb_ready_valid_enq_source: directed and random checks against a queue model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ready_valid_enq_source;

  localparam int WIDTH = 5;
  localparam int DEPTH = 2;

  logic             CLK = 1'b0;
  logic             RESETN;
  logic             I0;
  logic [WIDTH-1:0] I1;
  logic             full;
`ifdef RV_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_data;
  int               m_drop;

  ready_valid_enq_source_if #(.WIDTH(WIDTH)) bus ();

  ready_valid_enq_source #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .I0       (I0),
    .I1       (I1),
    .full     (full),
`ifdef RV_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .deq      (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the reference model across the edge, then compare.
  task automatic step(input logic rstn, input logic i0, input logic [WIDTH-1:0] d,
                      input logic rdy);
    bit was_full;
    bit do_pop;
    RESETN      = rstn;
    I0          = i0;
    I1          = d;
    bus.O_ready = rdy;
    @(posedge CLK);
    if (!rstn) begin
      q.delete();
      m_data = '0;
      m_drop = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && rdy;
      if (i0 && was_full && m_drop < 255) m_drop++;
      if (do_pop) void'(q.pop_front());
      if (i0 && !was_full) q.push_back(d);
      if (q.size() != 0) m_data = q[0];
    end
    #1;
    chk("valid", 32'(bus.O_valid), 32'(q.size() != 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("data", 32'(bus.O_data), 32'(m_data));
`ifdef RV_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  initial begin
    RESETN = 1'b0; I0 = 1'b0; I1 = '0; bus.O_ready = 1'b0;
    m_data = '0; m_drop = 0;

    // Reset held with push/ready active
    repeat (3) step(1'b0, 1'b1, 5'h15, 1'b1);
    chk("rst_valid", 32'(bus.O_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data", 32'(bus.O_data), 32'd0);

    // Stream 1..4 with consumer always ready
    step(1'b1, 1'b1, 5'd1, 1'b1);
    chk("stream_first", 32'(bus.O_data), 32'd1);
    step(1'b1, 1'b1, 5'd2, 1'b1);
    chk("stream_second", 32'(bus.O_data), 32'd2);
    step(1'b1, 1'b1, 5'd3, 1'b1);
    step(1'b1, 1'b1, 5'd4, 1'b1);
    chk("stream_fourth", 32'(bus.O_data), 32'd4);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("stream_drained", 32'(bus.O_valid), 32'd0);

    // Back-pressure hold
    step(1'b1, 1'b1, 5'h0A, 1'b0);
    repeat (5) step(1'b1, 1'b0, 5'h00, 1'b0);
    chk("bp_hold_data", 32'(bus.O_data), 32'h0A);
    chk("bp_hold_valid", 32'(bus.O_valid), 32'd1);
    step(1'b1, 1'b0, 5'h00, 1'b1);
    chk("bp_popped", 32'(bus.O_valid), 32'd0);

    // Fill, refuse third push, drain
    step(1'b1, 1'b1, 5'd7, 1'b0);
    step(1'b1, 1'b1, 5'd8, 1'b0);
    chk("full_after_two", 32'(full), 32'd1);
    step(1'b1, 1'b1, 5'd9, 1'b0);
    chk("full_head", 32'(bus.O_data), 32'd7);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("drain_8", 32'(bus.O_data), 32'd8);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("drain_empty", 32'(bus.O_valid), 32'd0);

    // Full with simultaneous push and pop
    step(1'b1, 1'b1, 5'd3, 1'b0);
    step(1'b1, 1'b1, 5'd6, 1'b0);
    step(1'b1, 1'b1, 5'h1F, 1'b1);
    chk("fullpop_full", 32'(full), 32'd0);
    chk("fullpop_head", 32'(bus.O_data), 32'd6);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("fullpop_one_left", 32'(bus.O_valid), 32'd0);

    // Reset with words queued
    step(1'b1, 1'b1, 5'h11, 1'b0);
    step(1'b1, 1'b1, 5'h12, 1'b0);
    step(1'b0, 1'b1, 5'h13, 1'b0);
    chk("midrst_valid", 32'(bus.O_valid), 32'd0);
    chk("midrst_full", 32'(full), 32'd0);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("midrst_no_words", 32'(bus.O_valid), 32'd0);

    // Random traffic, rare resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           WIDTH'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0));
    end
    // Long refused-push run to exercise the drop counter saturation
    step(1'b1, 1'b1, 5'd1, 1'b0);
    step(1'b1, 1'b1, 5'd2, 1'b0);
    repeat (270) step(1'b1, 1'b1, 5'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
